// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between a UART receiver and its consumer.
// It captures bytes on the receiver's done strobe and offers them on a valid/ready stream.
// Handshake: a byte transfers on any clock edge where m_valid_o and m_ready_i are both high.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          rx_d_i,
  input  logic                       rx_done_i,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  input  logic                       flush_i,
  input  logic                       ovr_clr_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       overrun_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovr_q, ovr_d;
  logic              push, pop, push_acc, pop_acc, full;

  assign full = (count_q == DEPTH_C);
  assign push = rx_done_i;
  assign pop  = m_valid_o & m_ready_i;

  // A full FIFO still takes a byte if the head leaves on the same edge.
  assign push_acc = push & (~full | pop) & ~flush_i;
  assign pop_acc  = pop & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
      else if (!push_acc && pop_acc) count_d = count_q - 1'b1;
    end
    // A fresh overrun wins over a clear in the same cycle.
    if (push && full && !pop && !flush_i) ovr_d = 1'b1;
    else if (ovr_clr_i)                  ovr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= rx_d_i;
  end

  assign m_valid_o = (count_q != '0);
  assign m_data_o  = m_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o   = count_q;
  assign full_o    = full;
  assign overrun_o = ovr_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] rx_d_i = '0;
  logic         rx_done_i = 1'b0;
  logic [W-1:0] m_data_o;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         ovr_clr_i = 1'b0;
  logic [4:0]   count_o;
  logic         full_o;
  logic         overrun_o;

  logic [W-1:0] exp_q[$];
  logic         exp_ovr = 1'b0;
  int           checks = 0;
  int           failures = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .rx_d_i(rx_d_i), .rx_done_i(rx_done_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .flush_i(flush_i), .ovr_clr_i(ovr_clr_i), .count_o(count_o),
    .full_o(full_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [W-1:0] hd;
    hd = (exp_q.size() > 0) ? exp_q[0] : '0;
    chk({tag, ".count"}, 32'(count_o), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(m_valid_o), 32'(exp_q.size() > 0));
    chk({tag, ".data"}, 32'(m_data_o), 32'(hd));
    chk({tag, ".full"}, 32'(full_o), 32'(exp_q.size() == DEPTH));
    chk({tag, ".ovr"}, 32'(overrun_o), 32'(exp_ovr));
  endtask

  // One clock: drive inputs, let the edge happen, update the model, then check.
  task automatic cycle(input string tag, input logic push, input logic [W-1:0] d,
                       input logic rdy, input logic fl, input logic clr);
    int  n;
    logic pop;
    rx_done_i = push; rx_d_i = d; m_ready_i = rdy; flush_i = fl; ovr_clr_i = clr;
    n   = exp_q.size();
    pop = rdy && (n > 0);
    @(posedge clk);
    if (push && n == DEPTH && !pop && !fl) exp_ovr = 1'b1;
    else if (clr)                         exp_ovr = 1'b0;
    if (fl) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (push && (n < DEPTH || pop)) exp_q.push_back(d);
    end
    #1;
    rx_done_i = 1'b0; m_ready_i = 1'b0; flush_i = 1'b0; ovr_clr_i = 1'b0;
    chk_all(tag);
  endtask

  initial begin
    logic [W-1:0] b;
    // 1: reset state, single byte in and out
    #3;
    chk_all("reset");
    @(posedge clk); #1 reset = 1'b0;
    cycle("t1_push", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("t1_head", 32'(m_data_o), 32'h000000A5);
    cycle("t1_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t1_empty_data", 32'(m_data_o), 32'h0);

    // 2: fill to full with back-pressure, then drain in order
    for (int i = 0; i < DEPTH; i++) cycle("t2_fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
    chk("t2_full", 32'(full_o), 32'h1);
    chk("t2_count", 32'(count_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", 32'(m_data_o), 32'(i));
      cycle("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // 3: overrun when full, dropped byte never appears, clear
    for (int i = 0; i < DEPTH; i++) cycle("t3_fill", 1'b1, W'($urandom_range(0, 8'hED)), 1'b0, 1'b0, 1'b0);
    cycle("t3_ovr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("t3_ovr_flag", 32'(overrun_o), 32'h1);
    chk("t3_ovr_count", 32'(count_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_no_ee_valid", 32'(m_data_o == 8'hEE), 32'h0);
      cycle("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    cycle("t3_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_clr_flag", 32'(overrun_o), 32'h0);

    // 4: full with simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) cycle("t4_fill", 1'b1, W'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    cycle("t4_pushpop", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t4_no_ovr", 32'(overrun_o), 32'h0);
    chk("t4_count", 32'(count_o), 32'd16);
    for (int i = 0; i < DEPTH - 1; i++) cycle("t4_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_last", 32'(m_data_o), 32'h55);
    cycle("t4_last_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 5: single entry, push and pop together across pointer wrap
    cycle("t5_seed", 1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      b = W'($urandom_range(0, 255));
      cycle("t5_pp", 1'b1, b, 1'b1, 1'b0, 1'b0);
      chk("t5_new_head", 32'(m_data_o), 32'(b));
    end
    cycle("t5_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 6: flush with push while overrun is set, then async reset mid-drain
    for (int i = 0; i < DEPTH; i++) cycle("t6_fill", 1'b1, W'(i + 3), 1'b0, 1'b0, 1'b0);
    cycle("t6_ovr", 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    cycle("t6_flush_full", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle("t6_fill5", 1'b1, W'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    cycle("t6_flush", 1'b1, 8'h33, 1'b1, 1'b1, 1'b0);
    chk("t6_flush_count", 32'(count_o), 32'd0);
    chk("t6_flush_ovr", 32'(overrun_o), 32'h1);
    for (int i = 0; i < 6; i++) cycle("t6_refill", 1'b1, W'(i + 8'h60), 1'b0, 1'b0, 1'b0);
    cycle("t6_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    exp_q.delete();
    exp_ovr = 1'b0;
    chk_all("t6_async_reset");
    @(posedge clk); #1 reset = 1'b0;
    chk_all("t6_post_reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 99) < 60), W'($urandom_range(0, 255)),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 2),
            1'($urandom_range(0, 99) < 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
